// File: rtl/crc7.sv
// Bit-serial CRC-7 for SD command/response frames: one frame bit per clock,
// MSB first; result and crc_ready are held after the last bit until reset.
module crc7 #(
  parameter int         DATA_W = 40,
  parameter logic [6:0] POLY   = 7'h09
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  output logic              crc_ready,
  output logic [6:0]        crc
);
  localparam int IW = $clog2(DATA_W);

  typedef enum logic {CALC, DONE} state_t;

  state_t            state_q;
  logic [IW-1:0]     index_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] src;
  logic [6:0]        crc_q, crc_d;
  logic              ready_q;
  logic              fb;

  // The first bit comes straight from data_in so a reset pulse that spans
  // no clock edge still starts from the current frame (held stable by contract).
  assign src   = (index_q == IW'(DATA_W-1)) ? data_in : data_q;
  assign fb    = src[DATA_W-1] ^ crc_q[6];
  assign crc_d = {crc_q[5:0], 1'b0} ^ (fb ? POLY : 7'h00);

  always_ff @(posedge clk) begin
    if (reset)                data_q <= data_in;
    else if (state_q == CALC) data_q <= {src[DATA_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CALC;
      index_q <= IW'(DATA_W-1);
      crc_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        CALC: begin
          crc_q   <= crc_d;
          index_q <= index_q - 1'b1;
          if (index_q == '0) begin
            state_q <= DONE;
            ready_q <= 1'b1;
          end
        end
        DONE: ;
        default: state_q <= CALC;
      endcase
    end
  end

  assign crc       = crc_q;
  assign crc_ready = ready_q;
endmodule

// File: tb/tb_crc7.sv
// Directed bench for crc7: known SD command CRCs, latency, hold and async reset.
module tb_crc7;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [39:0] data_in = '0;
  logic        crc_ready;
  logic [6:0]  crc;

  int errors = 0;
  int checks = 0;

  crc7 dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .crc_ready(crc_ready),
    .crc      (crc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] d;
    logic [6:0]  c;
    string       name;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse reset across one clock edge, release mid-cycle.
  task automatic start(input logic [39:0] d);
    @(negedge clk);
    data_in = d;
    reset   = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
  endtask

  // 39 edges: not ready; 40th edge: ready with expected crc.
  task automatic run_check(input string name, input logic [6:0] exp);
    repeat (39) @(posedge clk);
    #1 chk({name, " ready@39"}, {6'd0, crc_ready}, 7'd0);
    @(posedge clk);
    #1 chk({name, " ready@40"}, {6'd0, crc_ready}, 7'd1);
    chk({name, " crc"}, crc, exp);
  endtask

  initial begin
    vecs[0] = '{40'h40_0000_0000, 7'h4A, "CMD0"};
    vecs[1] = '{40'h51_0000_0000, 7'h2A, "CMD17"};
    vecs[2] = '{40'h11_0000_0900, 7'h33, "R1_CMD17"};
    vecs[3] = '{40'h00_0000_0000, 7'h00, "zero"};
    vecs[4] = '{40'h48_0000_01AA, 7'h43, "CMD8"};
    vecs[5] = '{40'h77_0000_0000, 7'h32, "CMD55"};
    vecs[6] = '{40'h69_4000_0000, 7'h3B, "ACMD41"};

    // Reset state
    #2;
    chk("reset crc", crc, 7'h00);
    chk("reset ready", {6'd0, crc_ready}, 7'd0);

    foreach (vecs[i]) begin
      start(vecs[i].d);
      run_check(vecs[i].name, vecs[i].c);
    end

    // Hold in DONE for 100 clocks while data_in toggles
    start(40'h40_0000_0000);
    run_check("hold_pre", 7'h4A);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      data_in = {$urandom, 8'($urandom)};
      @(posedge clk);
      #1;
      if (crc_ready !== 1'b1 || crc !== 7'h4A) begin
        chk("hold crc", crc, 7'h4A);
        chk("hold ready", {6'd0, crc_ready}, 7'd1);
      end else checks++;
    end

    // Async reset at edge 20 of CMD0
    start(40'h40_0000_0000);
    repeat (20) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset crc", crc, 7'h00);
    chk("midreset ready", {6'd0, crc_ready}, 7'd0);
    @(negedge clk);
    reset = 1'b0;
    run_check("after_midreset", 7'h4A);

    // Async reset in DONE clears immediately, then a new frame runs
    #2 reset = 1'b1;
    #1;
    chk("donereset crc", crc, 7'h00);
    chk("donereset ready", {6'd0, crc_ready}, 7'd0);
    start(40'h51_0000_0000);
    run_check("after_donereset", 7'h2A);

    // Reset pulse that spans no clock edge must still use the new frame
    @(negedge clk);
    data_in = 40'h48_0000_01AA;
    reset = 1'b1;
    #1 reset = 1'b0;
    run_check("short_reset", 7'h43);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/crc7.md
Name: crc7

Overview:
- Serial CRC-7 generator for SD-card command/response frames.
- Takes a 40-bit frame (start bit, transmission bit, 6-bit index, 32-bit argument) and computes the 7-bit CRC, one bit per clock, MSB first.
- Sits between the command builder and the CMD-line serializer; result is appended ahead of the end bit.

Parameters:
- DATA_W, 40, frame width fed into the CRC (fixed at 40 for SD commands/responses).
- POLY, 7'h09, generator polynomial x^7 + x^3 + 1 (lower 7 bits).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset; restarts the computation.
- data_in  input  40  frame to protect; bit 39 is sent first; must be held stable from reset release until crc_ready.
- crc_ready  output  1  high when crc holds the final result.
- crc  output  7  CRC-7 remainder; crc[6] is the MSB/first transmitted bit.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). All state updates on rising clk.
- Internal registers:
  - index[5:0]: bit pointer.
  - data[39:0]: working copy of the frame, shifted left one bit per cycle.
  - crc[6:0].
  - 2-state FSM: CALC, DONE.
- Reset (asserted, asynchronous):
  - crc = 0, crc_ready = 0, index = 39, state = CALC.
  - data is loaded with data_in while reset is high. The load is level-sensitive and follows data_in continuously during reset.
- CALC, each rising edge:
  - fb = data[39] ^ crc[6].
  - crc <= {crc[5:3], crc[2]^fb, crc[1:0], fb}.
  - data <= data << 1.
  - index <= index - 1.
  - When the edge processes index == 0 (the 40th bit): state <= DONE and crc_ready <= 1 on that same edge.
- Latency: crc valid and crc_ready high exactly 40 rising edges after reset deassertion.
- DONE:
  - crc and crc_ready hold indefinitely.
  - Changes on data_in are ignored until the next reset.
- crc_ready is registered. It is never high while state is CALC.
- Reset mid-operation: computation aborts immediately (async) and outputs clear. After release, the computation restarts from bit 39 of the current data_in.
- Reset in DONE: same as above. Reset is the only way to start a new computation.
- No handshake beyond crc_ready.
- crc is only meaningful when crc_ready = 1. Intermediate values are visible but unspecified for consumers.
- All-zero frame yields crc = 0.

Test Plan:
- data_in = 40'h40_0000_0000 (CMD0), pulse reset, wait 40 clocks -> crc = 7'b1001010 (0x4A), crc_ready = 1.
- data_in = 40'h51_0000_0000 (CMD17, arg 0), reset, wait 40 clocks -> crc = 7'b0101010 (0x2A), crc_ready = 1.
- data_in = 40'h11_0000_0900 (CMD17 response), reset, wait 40 clocks -> crc = 7'b0110011 (0x33), crc_ready = 1.
- Latency check, any frame:
  - crc_ready = 0 after 39 edges.
  - crc_ready = 1 after edge 40.
  - Stays 1 with crc unchanged for 100 further clocks while data_in toggles.
- Reset at edge 20 of a CMD0 computation:
  - crc = 0 and crc_ready = 0 immediately, before the next clk edge.
  - After release and 40 clocks -> 7'b1001010.
- data_in = 0, reset, 40 clocks -> crc = 7'b0000000, crc_ready = 1.
